rf_mp: RTL



---
 rtl/rf_pkg.sv | 13 +
 rtl/rf_clear_ctl.sv | 69 ++++++
 rtl/rf_mp.sv | 75 +++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared types and default parameters for the rf_mp register file.
package rf_pkg;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;

  localparam int RF_WIDTH_DEF = 32;
  localparam int RF_DEPTH_DEF = 64;
  localparam int RF_NRD_DEF   = 3;

endpackage

// File: rtl/rf_clear_ctl.sv
// Clear sequencer: walks every entry writing zero after reset or on clr,
// then parks in READY until the next clr.
//
// state    | meaning
// RF_CLEAR | zeroing entry[idx] each cycle; writes dropped, reads return 0
// RF_READY | normal operation
module rf_clear_ctl
  import rf_pkg::*;
#(
  parameter int DEPTH = RF_DEPTH_DEF,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  output logic          init_busy_o,
  output logic          clr_we_o,
  output logic [AW-1:0] clr_idx_o
);

  localparam logic [AW-1:0] IDX_LAST = AW'(DEPTH - 1);

  rf_state_e     state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RF_CLEAR;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      RF_CLEAR: begin
        if (clr_i) begin
          idx_d = '0;
        end else if (idx_q == IDX_LAST) begin
          state_d = RF_READY;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      RF_READY: begin
        if (clr_i) begin
          state_d = RF_CLEAR;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = RF_CLEAR;
        idx_d   = '0;
      end
    endcase
  end

  always_comb begin
    init_busy_o = (state_q == RF_CLEAR);
    clr_we_o    = (state_q == RF_CLEAR);
    clr_idx_o   = idx_q;
  end

endmodule

// File: rtl/rf_mp.sv
// Multi-port register file: NRD registered read ports, write ports D and E
// (E wins on address collision). Define RF_BYPASS_EN for write-to-read forwarding.
module rf_mp
  import rf_pkg::*;
#(
  parameter int WIDTH = RF_WIDTH_DEF,
  parameter int DEPTH = RF_DEPTH_DEF,
  parameter int NRD   = RF_NRD_DEF,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NRD*AW-1:0]    add_rd,
  output logic [NRD*WIDTH-1:0] do_rd,
  input  logic [AW-1:0]        add_d,
  input  logic [WIDTH-1:0]     di_d,
  input  logic                 we_d,
  input  logic [AW-1:0]        add_e,
  input  logic [WIDTH-1:0]     di_e,
  input  logic                 we_e,
  input  logic                 clr,
  output logic                 init_busy
);

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [NRD*WIDTH-1:0] do_rd_q, do_rd_d;
  logic                 clr_we;
  logic [AW-1:0]        clr_idx;
  logic                 wr_ok, wr_d, wr_e;

  rf_clear_ctl #(.DEPTH(DEPTH)) u_clear_ctl (
    .clk_i       (clk),
    .rst_i       (reset),
    .clr_i       (clr),
    .init_busy_o (init_busy),
    .clr_we_o    (clr_we),
    .clr_idx_o   (clr_idx)
  );

  // A clr arriving in READY takes precedence over any write in that cycle.
  assign wr_ok = ~init_busy & ~clr;
  assign wr_e  = wr_ok & we_e;
  assign wr_d  = wr_ok & we_d & ~(we_e & (add_e == add_d));

  // Storage has no reset; the clear sequencer defines its contents.
  always_ff @(posedge clk) begin
    if (clr_we) mem_q[clr_idx] <= '0;
    if (wr_d)   mem_q[add_d]   <= di_d;
    if (wr_e)   mem_q[add_e]   <= di_e;
  end

  always_comb begin
    do_rd_d = '0;
    for (int k = 0; k < NRD; k++) begin
      if (!init_busy) begin
        do_rd_d[k*WIDTH +: WIDTH] = mem_q[add_rd[k*AW +: AW]];
`ifdef RF_BYPASS_EN
        if (wr_e && (add_e == add_rd[k*AW +: AW])) begin
          do_rd_d[k*WIDTH +: WIDTH] = di_e;
        end else if (wr_d && (add_d == add_rd[k*AW +: AW])) begin
          do_rd_d[k*WIDTH +: WIDTH] = di_d;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) do_rd_q <= '0;
    else       do_rd_q <= do_rd_d;
  end

  assign do_rd = do_rd_q;

endmodule
